// File: rtl/restoring_divider_16bit.sv
// Multi-cycle unsigned 16-bit restoring divider (DIVU) with start/busy/done handshake.
// One quotient bit per clock; results are held in HI/LO-style registers until the next completion.
module restoring_divider_16bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] dividend_i,
  input  logic [15:0] divisor_i,
  output logic [15:0] quotient_o,
  output logic [15:0] remainder_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        div_by_zero_o
);

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e      state_q;
  logic [15:0] q_q;
  logic [15:0] m_q;
  logic [15:0] r_q;
  logic [3:0]  cnt_q;
  logic [15:0] quotient_q;
  logic [15:0] remainder_q;
  logic        done_q;
  logic        dbz_q;

  logic [16:0] r_shift;
  logic [16:0] trial;
  logic [15:0] r_d;
  logic [15:0] q_d;

  // The restored remainder is always below the divisor, so only the shifted value needs bit 16.
  always_comb begin
    r_shift = {r_q, q_q[15]};
    trial   = r_shift - {1'b0, m_q};
    r_d     = trial[16] ? r_shift[15:0] : trial[15:0];
    q_d     = {q_q[14:0], ~trial[16]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      q_q         <= '0;
      m_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (divisor_i == 16'd0) begin
              quotient_q  <= 16'hFFFF;
              remainder_q <= dividend_i;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
            end else begin
              q_q     <= dividend_i;
              m_q     <= divisor_i;
              r_q     <= '0;
              cnt_q   <= '0;
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            quotient_q  <= q_d;
            remainder_q <= r_d;
            dbz_q       <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign busy_o        = (state_q == StCalc);
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_restoring_divider_16bit.sv
// Self-checking bench for restoring_divider_16bit: directed cases plus random pairs,
// compared against plain-arithmetic division results.
module tb_restoring_divider_16bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  restoring_divider_16bit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .busy_o       (busy),
    .done_o       (done),
    .div_by_zero_o(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: DIVU semantics straight from the arithmetic definition.
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] eq, output logic [15:0] er, output logic ez);
    if (b == 16'd0) begin
      eq = 16'hFFFF;
      er = a;
      ez = 1'b1;
    end else begin
      eq = a / b;
      er = a % b;
      ez = 1'b0;
    end
  endtask

  // Issue one division; optionally pulse a second (ignored) start at CALC cycle inj.
  task automatic do_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int inj, input logic [15:0] ia, input logic [15:0] ib,
                        input bit full);
    logic [15:0] eq, er;
    logic        ez;
    int          n;
    int          busy_cnt;
    model(a, b, eq, er, ez);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    n        = 0;
    busy_cnt = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      if (inj > 0 && n + 1 == inj) begin
        start    = 1'b1;
        dividend = ia;
        divisor  = ib;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, " done_seen"}, 32'(done), 32'd1);
    if (full) begin
      check({tag, " latency"}, 32'(n), (b == 16'd0) ? 32'd0 : 32'd16);
      check({tag, " busy_cycles"}, 32'(busy_cnt), (b == 16'd0) ? 32'd0 : 32'd16);
      check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    end
    check({tag, " quotient"}, 32'(quotient), 32'(eq));
    check({tag, " remainder"}, 32'(remainder), 32'(er));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
    if (b != 16'd0) begin
      check({tag, " invariant"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      check({tag, " rem_lt_div"}, 32'(remainder < b), 32'd1);
    end
    @(negedge clk);
    if (full) check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " hold_q"}, 32'(quotient), 32'(eq));
  endtask

  initial begin
    logic [15:0] eq, er;
    logic        ez;
    logic [15:0] ra, rb;
    int          n;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_div("100/7", 16'd100, 16'd7, 0, '0, '0, 1'b1);
    do_div("FFFF/1", 16'hFFFF, 16'h0001, 0, '0, '0, 1'b1);
    do_div("5/9", 16'd5, 16'd9, 0, '0, '0, 1'b1);
    do_div("1234/0", 16'h1234, 16'h0000, 0, '0, '0, 1'b1);
    do_div("ABE2/CD+inj", 16'hABE2, 16'h00CD, 5, 16'h0010, 16'h0002, 1'b1);

    // Reset in the middle of a calculation.
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'h5AA5;
    divisor  = 16'h0003;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("midrst busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst quotient", 32'(quotient), 32'd0);
    check("midrst remainder", 32'(remainder), 32'd0);
    check("midrst flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    n = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    check("midrst no_done", 32'(n), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_div("5AA5/3", 16'h5AA5, 16'h0003, 0, '0, '0, 1'b1);

    // Back-to-back with start held high.
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'hFF13;
    divisor  = 16'h0031;
    @(negedge clk);
    dividend = 16'h1010;
    divisor  = 16'h0101;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    model(16'hFF13, 16'h0031, eq, er, ez);
    check("b2b first done", 32'(done), 32'd1);
    check("b2b first quotient", 32'(quotient), 32'(eq));
    check("b2b first remainder", 32'(remainder), 32'(er));
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    model(16'h1010, 16'h0101, eq, er, ez);
    check("b2b gap", 32'(n), 32'd17);
    check("b2b second quotient", 32'(quotient), 32'(eq));
    check("b2b second remainder", 32'(remainder), 32'(er));
    check("b2b second dbz", 32'(div_by_zero), 32'(ez));

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = 16'd0;
        1:       rb = 16'($urandom_range(1, 15));
        2:       rb = 16'hFFFF - 16'($urandom_range(0, 3));
        default: rb = 16'($urandom);
      endcase
      do_div("rand", ra, rb, 0, '0, '0, (i % 50) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
